// File: rtl/opcode_alu_pipe.sv
// -----------------------------------------------------------------------------
// opcode_alu_pipe
//
// Two-stage pipelined ALU with a valid/ready handshake on both sides.
// S1 captures an operand/opcode beat. S2 holds the computed result and drives
// the out_* payload. An internal accumulator (ACC/CLR) and a saturating
// illegal-opcode counter update only when a beat moves from S1 to S2, so each
// instruction updates them exactly once and in program order.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   in_valid/in_ready  input handshake
//   in_op[3:0]         opcode (0..8 legal, 9..15 take the error path)
//   in_a, in_b         WIDTH-bit operands
//   out_valid/out_ready output handshake
//   out_result         WIDTH-bit result
//   out_carry          carry (ADD) or borrow (SUB), else 0
//   out_zero           out_result == 0
//   out_err            beat carried an illegal opcode
//   acc_value          current accumulator register
//   illegal_cnt        saturating count of illegal opcodes executed
// -----------------------------------------------------------------------------
module opcode_alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err,
    output logic [WIDTH-1:0] acc_value,
    output logic [CNTW-1:0]  illegal_cnt
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_ACC = 4'd7;
    localparam logic [3:0] OP_CLR = 4'd8;

    // Stage 1: captured input beat
    logic             s1_valid_q;
    logic [3:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    // Stage 2: computed result
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_result_q;
    logic             s2_carry_q;
    logic             s2_zero_q;
    logic             s2_err_q;

    // Architectural state
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    // Result computed from S1 contents
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             err_d;

    logic             s2_free;
    logic             move;
    logic             in_fire;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] acc_sum;
    logic [SHW-1:0]   shamt;

    // Handshake: S2 can take a new beat when empty or draining this edge;
    // S1 can take a new beat when empty or moving into S2 this edge.
    assign s2_free  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;
    assign move     = s1_valid_q && s2_free;
    assign in_fire  = in_valid && in_ready;

    // One extra bit captures carry out of ADD and the borrow of SUB
    // (the top bit of the widened difference is set exactly when a < b).
    assign sum_w   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign diff_w  = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    assign acc_sum = acc_q + s1_a_q;
    assign shamt   = s1_b_q[SHW-1:0];

    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a value unassigned, which would infer a latch.
        res_d   = '0;
        carry_d = 1'b0;
        err_d   = 1'b0;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (s1_op_q)
            OP_ADD: begin
                res_d   = sum_w[WIDTH-1:0];
                carry_d = sum_w[WIDTH];
            end
            OP_SUB: begin
                res_d   = diff_w[WIDTH-1:0];
                carry_d = diff_w[WIDTH];
            end
            OP_AND: res_d = s1_a_q & s1_b_q;
            OP_OR:  res_d = s1_a_q | s1_b_q;
            OP_XOR: res_d = s1_a_q ^ s1_b_q;
            OP_SHL: res_d = s1_a_q << shamt;
            OP_SHR: res_d = s1_a_q >> shamt;
            OP_ACC: begin
                acc_d = acc_sum;
                res_d = acc_sum;
            end
            OP_CLR: begin
                acc_d = '0;
                res_d = acc_q;
            end
            default: begin
                err_d = 1'b1;
                if (cnt_q != {CNTW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_op_q    <= in_op;
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
        end else if (move) begin
            s1_valid_q <= 1'b0;
        end
    end

    // S2 payload only changes on a move, so it holds steady while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_carry_q  <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_err_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else if (move) begin
            s2_valid_q  <= 1'b1;
            s2_result_q <= res_d;
            s2_carry_q  <= carry_d;
            s2_zero_q   <= (res_d == '0);
            s2_err_q    <= err_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end else if (out_ready) begin
            s2_valid_q  <= 1'b0;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_carry   = s2_carry_q;
    assign out_zero    = s2_zero_q;
    assign out_err     = s2_err_q;
    assign acc_value   = acc_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_opcode_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_opcode_alu_pipe
//
// Scoreboard bench for opcode_alu_pipe (WIDTH=8, CNTW=8). The driver pushes an
// expected beat (result, flags, accumulator and illegal count after that
// instruction) into a queue when an input transfer happens; an independent
// monitor pops and compares on every output transfer and checks that a
// stalled payload stays stable. Directed beats carry hand-computed values;
// the random phase uses a small reference model.
// -----------------------------------------------------------------------------
module tb_opcode_alu_pipe;

    localparam int WIDTH = 8;
    localparam int CNTW  = 8;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3,
                           XOR_ = 4'd4, SHL = 4'd5, SHR = 4'd6, ACC = 4'd7,
                           CLR = 4'd8, ILL = 4'd9;

    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       zero;
        logic       err;
        logic [7:0] acc;
        logic [7:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;
    logic [WIDTH-1:0] acc_value;
    logic [CNTW-1:0]  illegal_cnt;

    exp_t       sb[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    logic [7:0] m_acc;
    logic [7:0] m_cnt;

    opcode_alu_pipe #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_carry   (out_carry),
        .out_zero    (out_zero),
        .out_err     (out_err),
        .acc_value   (acc_value),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic c, input logic e,
                                input logic [7:0] acc, input logic [7:0] cnt);
        exp_t x;
        x.result = r;
        x.carry  = c;
        x.zero   = (r == 8'h00);
        x.err    = e;
        x.acc    = acc;
        x.cnt    = cnt;
        return x;
    endfunction

    // Reference model for the random phase; keeps its own acc/count.
    task automatic model_step(input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, output exp_t e);
        int s;
        e = '0;
        case (op)
            ADD:  begin s = a + b; e.result = s[7:0]; e.carry = (s > 255); end
            SUB:  begin e.result = a - b; e.carry = (a < b); end
            AND_: e.result = a & b;
            OR_:  e.result = a | b;
            XOR_: e.result = a ^ b;
            SHL:  e.result = a << b[2:0];
            SHR:  e.result = a >> b[2:0];
            ACC:  begin m_acc = m_acc + a; e.result = m_acc; end
            CLR:  begin e.result = m_acc; m_acc = 8'h00; end
            default: begin
                e.err = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
            end
        endcase
        e.zero = (e.result == 8'h00);
        e.acc  = m_acc;
        e.cnt  = m_cnt;
    endtask

    // One cycle of stimulus: drive at the falling edge, decide acceptance 1ns later.
    task automatic step(input logic v, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ordy, input logic hand,
                        input exp_t he, output logic accepted);
        exp_t me;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        accepted = v && in_ready;
        if (accepted) begin
            model_step(op, a, b, me);
            sb.push_back(hand ? he : me);
        end
    endtask

    task automatic idle();
        logic ok;
        step(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0, '0, ok);
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic hand, input exp_t he);
        logic ok;
        int   n = 0;
        do begin
            step(1'b1, op, a, b, 1'b1, hand, he, ok);
            n++;
        end while (!ok && n < 100);
        if (!ok) check("send_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            idle();
            n++;
        end
        if (n >= 200) check("drain_done", sb.size(), 32'd0);
    endtask

    // Monitor: compares every output transfer against the queue head.
    initial begin : monitor
        exp_t got, want, held_v;
        logic held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            got.result = out_result;
            got.carry  = out_carry;
            got.zero   = out_zero;
            got.err    = out_err;
            got.acc    = acc_value;
            got.cnt    = illegal_cnt;
            if (rst || !out_valid) begin
                held = 1'b0;
            end else begin
                if (held) check("hold_stable", {5'b0, got}, {5'b0, held_v});
                if (out_ready) begin
                    check("beat_expected", {31'b0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) begin
                        want = sb.pop_front();
                        check("beat", {5'b0, got}, {5'b0, want});
                    end
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    held_v = got;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic       ok;
        int         t0, idx, got_n, cyc_n;
        logic [7:0] bp_a [4];
        logic [7:0] bp_b [4];
        exp_t       bp_e [4];
        logic       v, ordy;
        logic [3:0] op;
        logic [7:0] a, b;

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        m_acc = 8'h00; m_cnt = 8'h00;

        // Reset state
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_payload", {21'b0, out_result, out_carry, out_zero, out_err}, 32'd0);
        check("rst_acc", {24'b0, acc_value}, 32'd0);
        check("rst_cnt", {24'b0, illegal_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Latency: accept at edge N, out_valid after edge N+1
        step(1'b1, ADD, 8'hF0, 8'h20, 1'b1, 1'b1, mk(8'h10, 1, 0, 8'h00, 8'h00), ok);
        check("lat_accept", {31'b0, ok}, 32'd1);
        idle();
        check("lat_s1_only", {31'b0, out_valid}, 32'd0);
        idle();
        check("lat_out", {31'b0, out_valid}, 32'd1);
        drain();

        // Basic ops
        send(SUB,  8'h05, 8'h07, 1, mk(8'hFE, 1, 0, 8'h00, 8'h00));
        send(XOR_, 8'hAA, 8'hFF, 1, mk(8'h55, 0, 0, 8'h00, 8'h00));
        send(SHL,  8'h81, 8'h01, 1, mk(8'h02, 0, 0, 8'h00, 8'h00));
        send(SHL,  8'h81, 8'h09, 1, mk(8'h02, 0, 0, 8'h00, 8'h00));
        send(AND_, 8'hF0, 8'h3C, 1, mk(8'h30, 0, 0, 8'h00, 8'h00));
        send(OR_,  8'h0F, 8'h30, 1, mk(8'h3F, 0, 0, 8'h00, 8'h00));
        send(SHR,  8'h80, 8'h0F, 1, mk(8'h01, 0, 0, 8'h00, 8'h00));
        send(ADD,  8'hFF, 8'h01, 1, mk(8'h00, 1, 0, 8'h00, 8'h00));
        send(SUB,  8'h07, 8'h07, 1, mk(8'h00, 0, 0, 8'h00, 8'h00));
        drain();

        // Default path
        send(ILL, 8'h12, 8'h34, 1, mk(8'h00, 0, 1, 8'h00, 8'h01));
        drain();
        check("ill_acc", {24'b0, acc_value}, 32'd0);
        check("ill_cnt", {24'b0, illegal_cnt}, 32'd1);

        // Accumulator, back-to-back at full throughput
        t0 = cyc;
        send(CLR, 8'h00, 8'h00, 1, mk(8'h00, 0, 0, 8'h00, 8'h01));
        send(ACC, 8'h80, 8'h00, 1, mk(8'h80, 0, 0, 8'h80, 8'h01));
        send(ACC, 8'h90, 8'h00, 1, mk(8'h10, 0, 0, 8'h10, 8'h01));
        send(CLR, 8'h00, 8'h00, 1, mk(8'h10, 0, 0, 8'h00, 8'h01));
        check("acc_throughput", cyc - t0, 32'd4);
        drain();
        check("acc_cleared", {24'b0, acc_value}, 32'd0);

        // Illegal counter saturation
        for (int k = 0; k < 300; k++) begin
            send(4'(9 + k % 7), 8'(k), 8'(~k), 1,
                 mk(8'h00, 0, 1, 8'h00, (k + 2 > 255) ? 8'hFF : 8'(k + 2)));
        end
        drain();
        check("cnt_saturated", {24'b0, illegal_cnt}, 32'd255);

        // Backpressure: 4 ADDs, out_ready low for 5 cycles
        bp_a = '{8'h01, 8'h10, 8'h7F, 8'h80};
        bp_b = '{8'h02, 8'h20, 8'h01, 8'h80};
        bp_e[0] = mk(8'h03, 0, 0, 8'h00, 8'hFF);
        bp_e[1] = mk(8'h30, 0, 0, 8'h00, 8'hFF);
        bp_e[2] = mk(8'h80, 0, 0, 8'h00, 8'hFF);
        bp_e[3] = mk(8'h00, 1, 0, 8'h00, 8'hFF);
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, ADD, bp_a[idx], bp_b[idx], 1'b0, 1'b1, bp_e[idx], ok);
            if (ok) idx++;
        end
        check("bp_accepts", idx, 32'd2);
        check("bp_full", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        check("bp_held_result", {24'b0, out_result}, 32'h03);
        while (idx < 4) begin
            send(ADD, bp_a[idx], bp_b[idx], 1, bp_e[idx]);
            idx++;
        end
        drain();

        // Random handshake against the model
        got_n = 0;
        cyc_n = 0;
        while (got_n < 1000 && cyc_n < 20000) begin
            v    = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            op   = 4'($urandom_range(0, 15));
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            step(v, op, a, b, ordy, 1'b0, '0, ok);
            if (ok) got_n++;
            cyc_n++;
        end
        if (got_n < 1000) check("random_progress", got_n, 32'd1000);
        drain();
        check("rand_acc", {24'b0, acc_value}, {24'b0, m_acc});
        check("rand_cnt", {24'b0, illegal_cnt}, {24'b0, m_cnt});

        // Reset mid-stream with both stages full
        send(CLR, 8'h00, 8'h00, 0, '0);
        send(ACC, 8'h33, 8'h00, 0, '0);
        drain();
        check("pre_rst_acc", {24'b0, acc_value}, 32'h33);
        step(1'b1, ADD, 8'h05, 8'h06, 1'b0, 1'b0, '0, ok);
        step(1'b1, ADD, 8'h07, 8'h08, 1'b0, 1'b0, '0, ok);
        step(1'b1, ADD, 8'h09, 8'h09, 1'b0, 1'b0, '0, ok);
        check("pre_rst_full", {31'b0, in_ready}, 32'd0);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_payload", {21'b0, out_result, out_carry, out_zero, out_err}, 32'd0);
        check("arst_acc", {24'b0, acc_value}, 32'd0);
        check("arst_cnt", {24'b0, illegal_cnt}, 32'd0);
        sb.delete();
        m_acc = 8'h00;
        m_cnt = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        send(ADD, 8'h01, 8'h01, 1, mk(8'h02, 0, 0, 8'h00, 8'h00));
        drain();
        repeat (5) idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/opcode_alu_pipe.md
# opcode_alu_pipe

Parametrised, pipelined successor to the combinational 3-bit-opcode ALU. It accepts operand/opcode beats over a valid/ready handshake and computes one of nine operations on WIDTH-bit operands. It holds an internal accumulator, and every opcode without an explicit operation takes a defined default path that flags an error. It sits between an instruction decoder and a result writeback stage, and applies full backpressure in both directions.

## Interface
- WIDTH, 8, operand/result width (≥2, power of two).
- CNTW, 8, width of saturating illegal-opcode counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept input beat this cycle.
- in_op  in  4  opcode.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- out_result  out  WIDTH  result.
- out_carry  out  1  carry/borrow flag (ADD/SUB only, else 0).
- out_zero  out  1  out_result == 0.
- out_err  out  1  beat carried an illegal opcode.
- acc_value  out  WIDTH  current accumulator register.
- illegal_cnt  out  CNTW  saturating count of illegal opcodes executed.

## Operation
- Two registered stages: S1 (captured input), S2 (computed result, drives out_*).
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Advance rule: s2_free = !s2_valid || out_ready; in_ready = !s1_valid || s2_free (combinational, no dependency on in_valid).
- S1→S2 move occurs when s1_valid && s2_free; the result is computed from S1 contents at that edge.
- Opcodes (arithmetic modulo 2^WIDTH):
  - 0 ADD: a+b; carry = bit WIDTH of the full sum.
  - 1 SUB: a−b; carry = 1 iff a<b (borrow).
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 SHL / 6 SHR: logical shift of a by b[log2(WIDTH)-1:0]; zero fill.
  - 7 ACC: acc ← acc+a; result = new acc.
  - 8 CLR: acc ← 0; result = old acc.
  - 9–15 default (illegal): result 0, carry 0, err 1, acc unchanged, illegal_cnt += 1, saturating at 2^CNTW−1.
- Accumulator and illegal_cnt update only on the S1→S2 move, so they update exactly once per instruction in program order.
- The out_* payload is held stable while out_valid && !out_ready.
- No beat is dropped or duplicated under any in_valid/out_ready pattern.

## Timing
- Latency: an input accepted at edge N produces out_valid high after edge N+1, provided there is no backpressure.
- Throughput: 1 beat/cycle while out_ready stays high.
- Full: both stages valid and out_ready=0 → in_ready=0.
- Simultaneous output transfer and S1→S2 move in the same edge: S2 reloads and out_valid stays 1.
- Simultaneous input accept and S1→S2 move: S1 reloads and s1_valid stays 1.
- ACC back-to-back: the second ACC sees the accumulator already updated by the first. There is no hazard because the update and the read occur in the same stage.
- Reset (asynchronous, any time, including mid-stream):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - out_result=0, out_carry=0, out_zero=0, out_err=0.
  - acc_value=0, illegal_cnt=0.
  - in_ready=1 on the first cycle after release.
  - In-flight beats are discarded.

## Test plan
- Basic ops, WIDTH=8, out_ready=1: ADD 0xF0+0x20 → result 0x10, carry 1, at 2 cycles latency. SUB 0x05−0x07 → 0xFE, carry 1. XOR 0xAA^0xFF → 0x55. SHL 0x81<<1 → 0x02.
- Default path: op 9, a=0x12, b=0x34 → result 0x00, err 1, zero 1, acc unchanged, illegal_cnt 1. Then 300 illegal ops with CNTW=8 → illegal_cnt saturates at 255.
- Accumulator: CLR, then ACC 0x80, then ACC 0x90 → results 0x00 (old acc), 0x80, 0x10 (wrap). Then CLR → result 0x10, acc_value 0.
- Backpressure: stream 4 ADDs and hold out_ready=0 for 5 cycles → in_ready drops after 2 accepts and out_* stays stable. On release, all 4 results arrive in order with no loss.
- Random in_valid/out_ready at 50% over 1000 beats, checked against a reference model → exact in-order match, with acc_value and illegal_cnt matching the model.
- Assert rst while both stages are valid and acc=0x33 → all outputs 0 immediately (asynchronous). After release the first new beat ADD 1+1 → result 0x02 with no stale beat emitted.
